// File: rtl/gauss_row_arbiter.sv
// gauss_row_arbiter: row-granular round-robin share of one Gaussian FIFO.
// Optional GAUSS_ARB_STATS_EN adds per-requester completed-row counters.
module gauss_row_arbiter #(
    parameter int                DATA_W    = 8,
    parameter int                ROW_WIDTH = 400,
    parameter int                PAD_COUNT = 1,
    parameter logic [DATA_W-1:0] PAD_VALUE = 8'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_din,
    output logic              req0_rd_en,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_din,
    output logic              req1_rd_en,
    output logic [DATA_W-1:0] out_din,
    output logic              out_wr_en,
    input  logic              out_full,
    output logic              out_src,
    output logic              busy,
`ifdef GAUSS_ARB_STATS_EN
    output logic [15:0]       rows0,
    output logic [15:0]       rows1,
`endif
    output logic              row_done
);

    localparam int CW = (ROW_WIDTH > 1) ? $clog2(ROW_WIDTH) : 1;
    localparam int PC = $clog2(PAD_COUNT + 1);
    localparam int PW = (PC > 0) ? PC : 1;

    localparam logic [CW-1:0] ROW_LAST = CW'(ROW_WIDTH - 1);
    localparam logic [PW-1:0] PAD_LAST =
        PW'((PAD_COUNT > 0) ? PAD_COUNT - 1 : 0);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ROW  = 2'd1;
    localparam logic [1:0] PAD  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          grant_q, grant_d;
    logic          last_q, last_d;
    logic [CW-1:0] pix_q, pix_d;
    logic [PW-1:0] pad_q, pad_d;
    logic          done_q, done_d;

    logic src_valid;
    logic xfer;
    logic pad_wr;
    logic win;

    assign src_valid = grant_q ? req1_valid : req0_valid;
    assign xfer      = (state_q == ROW) && src_valid && !out_full;
    assign pad_wr    = (state_q == PAD) && !out_full;

    assign req0_rd_en = xfer && !grant_q;
    assign req1_rd_en = xfer && grant_q;
    assign out_wr_en  = xfer || pad_wr;
    assign out_src    = grant_q;
    assign busy       = (state_q != IDLE);
    assign row_done   = done_q;

    // Output mux: requester pass-through in ROW, pad value in PAD, zero idle.
    always_comb begin
        out_din = '0;
        if (state_q == PAD) begin
            out_din = PAD_VALUE;
        end else if (state_q == ROW) begin
            out_din = grant_q ? req1_din : req0_din;
        end
    end

    // Next-state: round-robin grant in IDLE, count pixels, then pad.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        pix_d   = pix_q;
        pad_d   = pad_q;
        done_d  = 1'b0;
        win     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    win = (req0_valid && req1_valid) ? ~last_q
                                                     : req1_valid;
                    grant_d = win;
                    last_d  = win;
                    pix_d   = '0;
                    state_d = ROW;
                end
            end
            ROW: begin
                if (xfer) begin
                    if (pix_q == ROW_LAST) begin
                        if (PAD_COUNT > 0) begin
                            state_d = PAD;
                            pad_d   = '0;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        pix_d = pix_q + 1'b1;
                    end
                end
            end
            PAD: begin
                if (pad_wr) begin
                    if (pad_q == PAD_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        pad_d = pad_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; last grant starts at 1 so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            pix_q   <= '0;
            pad_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            pix_q   <= pix_d;
            pad_q   <= pad_d;
            done_q  <= done_d;
        end
    end

`ifdef GAUSS_ARB_STATS_EN
    logic [15:0] rows0_q, rows1_q;

    assign rows0 = rows0_q;
    assign rows1 = rows1_q;

    // Count completed rows per owner, visible together with row_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows0_q <= '0;
            rows1_q <= '0;
        end else if (done_d) begin
            if (grant_q) begin
                rows1_q <= rows1_q + 16'd1;
            end else begin
                rows0_q <= rows0_q + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gauss_row_arbiter.sv
// Directed bench for gauss_row_arbiter: ROW_WIDTH=4 with one pad pixel
// (dut_a) and ROW_WIDTH=4 with padding disabled (dut_b).
module tb_gauss_row_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       a_v0, a_v1, a_rd0, a_rd1, a_wr, a_full;
    logic       a_src, a_busy, a_done;
    logic [7:0] a_d0, a_d1, a_dout;
    logic       b_v0, b_v1, b_rd0, b_rd1, b_wr, b_full;
    logic       b_src, b_busy, b_done;
    logic [7:0] b_d0, b_d1, b_dout;
`ifdef GAUSS_ARB_STATS_EN
    logic [15:0] a_rows0, a_rows1, b_rows0, b_rows1;
`endif

    int n_chk = 0;
    int n_fail = 0;

    gauss_row_arbiter #(
        .DATA_W(8), .ROW_WIDTH(4), .PAD_COUNT(1), .PAD_VALUE(8'hFF)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(a_v0), .req0_din(a_d0), .req0_rd_en(a_rd0),
        .req1_valid(a_v1), .req1_din(a_d1), .req1_rd_en(a_rd1),
        .out_din(a_dout), .out_wr_en(a_wr), .out_full(a_full),
        .out_src(a_src), .busy(a_busy),
`ifdef GAUSS_ARB_STATS_EN
        .rows0(a_rows0), .rows1(a_rows1),
`endif
        .row_done(a_done)
    );

    gauss_row_arbiter #(
        .DATA_W(8), .ROW_WIDTH(4), .PAD_COUNT(0), .PAD_VALUE(8'hFF)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(b_v0), .req0_din(b_d0), .req0_rd_en(b_rd0),
        .req1_valid(b_v1), .req1_din(b_d1), .req1_rd_en(b_rd1),
        .out_din(b_dout), .out_wr_en(b_wr), .out_full(b_full),
        .out_src(b_src), .busy(b_busy),
`ifdef GAUSS_ARB_STATS_EN
        .rows0(b_rows0), .rows1(b_rows1),
`endif
        .row_done(b_done)
    );

    task automatic do_reset();
        rst_n = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        a_v0 = 0; a_v1 = 0; a_d0 = 0; a_d1 = 0; a_full = 0;
        b_v0 = 0; b_v1 = 0; b_d0 = 0; b_d1 = 0; b_full = 0;
        rst_n = 1'b0;
        #12;
        n_chk++;
        if ({a_wr, a_rd0, a_rd1, a_busy, a_done, a_src} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctl got %b want 000000",
                {a_wr, a_rd0, a_rd1, a_busy, a_done, a_src});
        end
        n_chk++;
        if (a_dout !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_dout got %h want 00", a_dout);
        end
        n_chk++;
        if ({b_wr, b_busy, b_done, b_src} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_b got %b want 0000",
                {b_wr, b_busy, b_done, b_src});
        end
`ifdef GAUSS_ARB_STATS_EN
        n_chk++;
        if ({a_rows0, a_rows1} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_stats got %h want 0", {a_rows0, a_rows1});
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One requester, one row: 10,11,12,13,FF then row_done.
    task automatic test_single_row();
        logic [7:0] ew  [8] = '{0, 1, 1, 1, 1, 1, 0, 0};
        logic [7:0] er  [8] = '{0, 1, 1, 1, 1, 0, 0, 0};
        logic [7:0] ed  [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
        logic [7:0] edin[8] = '{0, 10, 11, 12, 13, 8'hFF, 0, 0};
        int idx = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            a_v0 = (idx < 4);
            a_d0 = 8'(10 + idx);
            @(negedge clk);
            n_chk++;
            if ({a_wr, a_rd0, a_rd1, a_done} !==
                {ew[c][0], er[c][0], 1'b0, ed[c][0]}) begin
                n_fail++;
                $display("FAIL single_ctl c=%0d got %b want %b", c,
                    {a_wr, a_rd0, a_rd1, a_done},
                    {ew[c][0], er[c][0], 1'b0, ed[c][0]});
            end
            if (ew[c][0]) begin
                n_chk++;
                if (a_dout !== edin[c]) begin
                    n_fail++;
                    $display("FAIL single_din c=%0d got %h want %h",
                        c, a_dout, edin[c]);
                end
            end
            n_chk++;
            if (a_src !== 1'b0) begin
                n_fail++;
                $display("FAIL single_src c=%0d got %b want 0", c, a_src);
            end
            if (er[c][0]) idx++;
        end
    endtask

    // Both requesters always valid: rows alternate 0,1,0,1.
    task automatic test_back_to_back();
        int cnt0 = 0;
        int cnt1 = 0;
        do_reset();
        for (int c = 0; c < 26; c++) begin
            int k, r;
            logic s, ew, er0, er1, edn, eb;
            logic [7:0] edin;
            k = c % 6;
            r = c / 6;
            s = r[0];
            @(posedge clk); #1;
            a_v0 = (c < 24);
            a_v1 = (c < 24);
            a_d0 = 8'(8'h20 + cnt0);
            a_d1 = 8'(8'h40 + cnt1);
            ew   = (k != 0) && (c < 24);
            er0  = (k >= 1) && (k <= 4) && !s && (c < 24);
            er1  = (k >= 1) && (k <= 4) && s && (c < 24);
            edn  = (k == 0) && (c > 0) && (c <= 24);
            eb   = ew;
            edin = (k == 5) ? 8'hFF : (s ? 8'(8'h40 + cnt1)
                                         : 8'(8'h20 + cnt0));
            @(negedge clk);
            n_chk++;
            if ({a_wr, a_rd0, a_rd1, a_done, a_busy} !==
                {ew, er0, er1, edn, eb}) begin
                n_fail++;
                $display("FAIL b2b_ctl c=%0d got %b want %b", c,
                    {a_wr, a_rd0, a_rd1, a_done, a_busy},
                    {ew, er0, er1, edn, eb});
            end
            if (ew) begin
                n_chk++;
                if (a_dout !== edin || a_src !== s) begin
                    n_fail++;
                    $display("FAIL b2b_data c=%0d got %h/%b want %h/%b",
                        c, a_dout, a_src, edin, s);
                end
            end
            if (er0) cnt0++;
            if (er1) cnt1++;
        end
    endtask

    // out_full for 3 cycles after the 2nd pixel stalls the row.
    task automatic test_stall();
        logic ew [10] = '{0, 1, 1, 0, 0, 0, 1, 1, 1, 0};
        logic er [10] = '{0, 1, 1, 0, 0, 0, 1, 1, 0, 0};
        logic ef [10] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0};
        int idx = 0;
        int writes = 0;
        for (int c = 0; c < 10; c++) begin
            logic [7:0] edin;
            @(posedge clk); #1;
            a_v0   = (idx < 4);
            a_d0   = 8'(8'h30 + idx);
            a_full = ef[c];
            edin   = (c == 8) ? 8'hFF : 8'(8'h30 + idx);
            @(negedge clk);
            if (a_wr === 1'b1) writes++;
            n_chk++;
            if ({a_wr, a_rd0, a_rd1} !== {ew[c], er[c], 1'b0}) begin
                n_fail++;
                $display("FAIL stall_ctl c=%0d got %b want %b", c,
                    {a_wr, a_rd0, a_rd1}, {ew[c], er[c], 1'b0});
            end
            if (ew[c]) begin
                n_chk++;
                if (a_dout !== edin) begin
                    n_fail++;
                    $display("FAIL stall_din c=%0d got %h want %h",
                        c, a_dout, edin);
                end
            end
            if (ef[c]) begin
                n_chk++;
                if (a_busy !== 1'b1 || a_src !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_busy c=%0d got %b%b want 10",
                        c, a_busy, a_src);
                end
            end
            if (er[c]) idx++;
        end
        n_chk++;
        if (writes != 5) begin
            n_fail++;
            $display("FAIL stall_writes got %0d want 5", writes);
        end
    endtask

    // req0 drops mid-row while req1 waits: row stays with requester 0.
    task automatic test_valid_drop();
        logic ew [9] = '{0, 1, 1, 0, 0, 1, 1, 1, 0};
        logic er [9] = '{0, 1, 1, 0, 0, 1, 1, 0, 0};
        logic v0 [9] = '{1, 1, 1, 0, 0, 1, 1, 0, 0};
        int idx = 0;
        for (int c = 0; c < 9; c++) begin
            logic [7:0] edin;
            @(posedge clk); #1;
            a_v0 = v0[c];
            a_d0 = 8'(8'h70 + idx);
            a_v1 = (c >= 1) && (c < 8);
            a_d1 = 8'hEE;
            edin = (c == 7) ? 8'hFF : 8'(8'h70 + idx);
            @(negedge clk);
            n_chk++;
            if ({a_wr, a_rd0, a_rd1, a_src} !==
                {ew[c], er[c], 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL drop_ctl c=%0d got %b want %b", c,
                    {a_wr, a_rd0, a_rd1, a_src},
                    {ew[c], er[c], 1'b0, 1'b0});
            end
            if (ew[c]) begin
                n_chk++;
                if (a_dout !== edin) begin
                    n_fail++;
                    $display("FAIL drop_din c=%0d got %h want %h",
                        c, a_dout, edin);
                end
            end
            if (er[c]) idx++;
        end
        n_chk++;
        if (a_done !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_done got %b want 1", a_done);
        end
    endtask

    // Async reset mid-row, then a fresh full row with no stale pad.
    task automatic test_reset_mid_row();
        logic ew [7] = '{1, 1, 1, 1, 1, 0, 0};
        logic er [7] = '{1, 1, 1, 1, 0, 0, 0};
        logic ed [7] = '{0, 0, 0, 0, 0, 1, 0};
        int idx = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            a_v0 = 1'b1;
            a_d0 = 8'(8'h80 + idx);
            @(negedge clk);
            if (c > 0) idx++;
        end
        @(posedge clk); #1;
        a_d0 = 8'(8'h80 + idx);
        #1;
        n_chk++;
        if (a_wr !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre got %b want 1", a_wr);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({a_wr, a_rd0, a_rd1, a_busy, a_done, a_src} !== 6'b0 ||
            a_dout !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_async got %b/%h want 000000/00",
                {a_wr, a_rd0, a_rd1, a_busy, a_done, a_src}, a_dout);
        end
        idx = 0;
        a_d0 = 8'h50;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 7; c++) begin
            logic [7:0] edin;
            @(posedge clk); #1;
            a_v0 = (idx < 4);
            a_d0 = 8'(8'h50 + idx);
            edin = (c == 4) ? 8'hFF : 8'(8'h50 + idx);
            @(negedge clk);
            n_chk++;
            if ({a_wr, a_rd0, a_done} !== {ew[c], er[c], ed[c]}) begin
                n_fail++;
                $display("FAIL midrst_ctl c=%0d got %b want %b", c,
                    {a_wr, a_rd0, a_done}, {ew[c], er[c], ed[c]});
            end
            if (ew[c]) begin
                n_chk++;
                if (a_dout !== edin) begin
                    n_fail++;
                    $display("FAIL midrst_din c=%0d got %h want %h",
                        c, a_dout, edin);
                end
            end
            if (er[c]) idx++;
        end
`ifdef GAUSS_ARB_STATS_EN
        n_chk++;
        if (a_rows0 !== 16'd1 || a_rows1 !== 16'd0) begin
            n_fail++;
            $display("FAIL midrst_stats got %0d/%0d want 1/0",
                a_rows0, a_rows1);
        end
`endif
    endtask

    // PAD_COUNT=0: three rows from requester 1, no pad pixels.
    task automatic test_no_pad();
        int cnt = 0;
        for (int c = 0; c < 17; c++) begin
            int k;
            logic ew, edn;
            @(posedge clk); #1;
            k    = c % 5;
            b_v1 = (c < 15);
            b_d1 = 8'(8'h60 + cnt);
            ew   = (k != 0) && (c < 15);
            edn  = (k == 0) && (c > 0) && (c <= 15);
            @(negedge clk);
            n_chk++;
            if ({b_wr, b_rd1, b_rd0, b_done} !== {ew, ew, 1'b0, edn}) begin
                n_fail++;
                $display("FAIL nopad_ctl c=%0d got %b want %b", c,
                    {b_wr, b_rd1, b_rd0, b_done}, {ew, ew, 1'b0, edn});
            end
            if (ew) begin
                n_chk++;
                if (b_dout !== 8'(8'h60 + cnt) || b_src !== 1'b1) begin
                    n_fail++;
                    $display("FAIL nopad_din c=%0d got %h/%b want %h/1",
                        c, b_dout, b_src, 8'(8'h60 + cnt));
                end
                cnt++;
            end
`ifdef GAUSS_ARB_STATS_EN
            if (c == 15) begin
                n_chk++;
                if (b_rows1 !== 16'd3 || b_rows0 !== 16'd0) begin
                    n_fail++;
                    $display("FAIL nopad_stats got %0d/%0d want 0/3",
                        b_rows0, b_rows1);
                end
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_back_to_back();
        test_stall();
        test_valid_drop();
        test_reset_mid_row();
        test_no_pad();
        $display("End of test - %0d assertions evaluated, %0d failures",
            n_chk, n_fail);
        $finish;
    end

endmodule
